// File: rtl/mem_source_pkg.sv
// Shared definitions for the interpolator stimulus source: state encoding,
// default widths and the skid-buffer depth.
package mem_source_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int DEF_ADDR_WIDTH   = 7;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_CONFIG_WIDTH = 32;
  localparam int SKID_DEPTH       = 2;

endpackage : mem_source_pkg

// File: rtl/mem_source_if.sv
// Handshake/bus bundle between the stimulus source, its sample memory and
// the interpolator input FIFO.
interface mem_source_if #(
  parameter int ADDR_WIDTH   = 7,
  parameter int DATA_WIDTH   = 32,
  parameter int CONFIG_WIDTH = 32
);
  logic                    start_i;
  logic                    Full_i;
  logic [CONFIG_WIDTH-1:0] ilen;
  logic                    mem_rd_en_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_data_i;
  logic [DATA_WIDTH-1:0]   data_o;
  logic                    Write_Enable_o;
  logic                    busy_o;
  logic                    done;

  modport master (
    input  start_i, Full_i, ilen, mem_data_i,
    output mem_rd_en_o, mem_addr_o, data_o, Write_Enable_o, busy_o, done
  );

  modport slave (
    output start_i, Full_i, ilen, mem_data_i,
    input  mem_rd_en_o, mem_addr_o, data_o, Write_Enable_o, busy_o, done
  );
endinterface : mem_source_if

// File: rtl/mem_source_skid_buf2.sv
// Two-entry register FIFO absorbing read data that returns while the
// downstream FIFO is full; slot0 is always the head.
module mem_source_skid_buf2
  import mem_source_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head
);

  logic [DATA_WIDTH-1:0] slot0_r;
  logic [DATA_WIDTH-1:0] slot1_r;
  logic [1:0]            cnt_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // Guard against overflow/underflow so a misbehaving caller cannot corrupt order
  always_comb begin
    pop_ok_s  = pop && (cnt_r != 2'd0);
    push_ok_s = push && ((cnt_r < 2'(SKID_DEPTH)) || pop_ok_s);
  end

  // Storage and occupancy update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_r <= {DATA_WIDTH{1'b0}};
      slot1_r <= {DATA_WIDTH{1'b0}};
      cnt_r   <= 2'd0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (cnt_r == 2'd0) begin
            slot0_r <= din;
          end else begin
            slot1_r <= din;
          end
          cnt_r <= cnt_r + 2'd1;
        end
        2'b01: begin
          slot0_r <= slot1_r;
          cnt_r   <= cnt_r - 2'd1;
        end
        2'b11: begin
          // count unchanged; new word lands behind whatever remains
          if (cnt_r == 2'd1) begin
            slot0_r <= din;
          end else begin
            slot0_r <= slot1_r;
            slot1_r <= din;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign count = cnt_r;
  assign head  = slot0_r;

endmodule : mem_source_skid_buf2

// File: rtl/mem_source.sv
// Stimulus source: on start, streams ilen words from a synchronous-read
// sample memory into the interpolator input FIFO, honouring Full_i.
module mem_source
  import mem_source_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH
) (
  input logic         clk,
  input logic         rst,
  mem_source_if.master bus
);

  localparam logic [CONFIG_WIDTH-1:0] CNT_ZERO = {CONFIG_WIDTH{1'b0}};
  localparam logic [CONFIG_WIDTH-1:0] CNT_ONE  = {{(CONFIG_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  state_t                  state_s;
  logic [CONFIG_WIDTH-1:0] len_q_r;
  logic [CONFIG_WIDTH-1:0] rd_cnt_r;
  logic [CONFIG_WIDTH-1:0] wr_cnt_r;
  logic [CONFIG_WIDTH-1:0] wr_inc_s;
  logic                    inflight_r;
  logic                    rd_en_s;
  logic                    load_s;
  logic                    pop_s;
  logic [2:0]              level_s;
  logic [1:0]              buf_cnt_s;
  logic [DATA_WIDTH-1:0]   buf_head_s;
  logic                    busy_r;
  logic                    done_r;

  mem_source_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_r),
    .pop   (pop_s),
    .din   (bus.mem_data_i),
    .count (buf_cnt_s),
    .head  (buf_head_s)
  );

  // Write strobe follows Full_i combinationally so a full FIFO never takes a word
  assign pop_s    = (buf_cnt_s != 2'd0) && !bus.Full_i;
  assign wr_inc_s = pop_s ? CNT_ONE : CNT_ZERO;

  // Next-state and read-issue decode
  always_comb begin
    state_s = state_r;
    rd_en_s = 1'b0;
    load_s  = 1'b0;
    level_s = {1'b0, buf_cnt_s} + {2'b00, inflight_r} - {2'b00, pop_s};
    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          load_s  = 1'b1;
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((rd_cnt_r < len_q_r) && (level_s < 3'(SKID_DEPTH))) begin
          rd_en_s = 1'b1;
        end else begin
          rd_en_s = 1'b0;
        end
        // look at the post-write count so done lands the cycle after the last write
        if ((wr_cnt_r + wr_inc_s) == len_q_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register with registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s == ST_RUN);
      done_r  <= (state_s == ST_DONE);
    end
  end

  // Transfer length, read/write counters and the one-deep in-flight flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q_r    <= CNT_ZERO;
      rd_cnt_r   <= CNT_ZERO;
      wr_cnt_r   <= CNT_ZERO;
      inflight_r <= 1'b0;
    end else if (load_s) begin
      len_q_r    <= bus.ilen;
      rd_cnt_r   <= CNT_ZERO;
      wr_cnt_r   <= CNT_ZERO;
      inflight_r <= 1'b0;
    end else begin
      if (rd_en_s) begin
        rd_cnt_r <= rd_cnt_r + CNT_ONE;
      end
      wr_cnt_r   <= wr_cnt_r + wr_inc_s;
      inflight_r <= rd_en_s;
    end
  end

  assign bus.mem_rd_en_o    = rd_en_s;
  assign bus.mem_addr_o     = rd_en_s ? rd_cnt_r[ADDR_WIDTH-1:0] : {ADDR_WIDTH{1'b0}};
  assign bus.Write_Enable_o = pop_s;
  assign bus.data_o         = buf_head_s;
  assign bus.busy_o         = busy_r;
  assign bus.done           = done_r;

endmodule : mem_source
